// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole sequencer.
package mole_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSpawn = 3'd1,
        StShow  = 3'd2,
        StGap   = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [1:0] LvlEasy = 2'd0;
    localparam logic [1:0] LvlMed  = 2'd1;

    localparam int unsigned LifeEasyDef = 15;
    localparam int unsigned LifeMedDef  = 10;
    localparam int unsigned LifeHardDef = 6;
    localparam int unsigned GoalEasyDef = 10;
    localparam int unsigned GoalMedDef  = 15;
    localparam int unsigned GoalHardDef = 20;

    // x^5 + x^3 + 1
    localparam logic [4:0] LfsrTaps = 5'b10100;

    function automatic logic [4:0] lfsr_next(input logic [4:0] s);
        return {s[3:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 5-bit Fibonacci LFSR; exposes the low nibble as a cell candidate.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [4:0] Seed = 5'b10011
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] cand_o
);

    logic [4:0] lfsr_q, lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cand_o = lfsr_q[3:0];

endmodule

// File: rtl/mole_game_ctrl.sv
// Game sequencer: mole scheduling, hit judging, score, game timer and result.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned GAME_SECS = 30,
    parameter int unsigned GAP_TICKS = 3,
    parameter int unsigned LIFE_EASY = LifeEasyDef,
    parameter int unsigned LIFE_MED  = LifeMedDef,
    parameter int unsigned LIFE_HARD = LifeHardDef,
    parameter int unsigned GOAL_EASY = GoalEasyDef,
    parameter int unsigned GOAL_MED  = GoalMedDef,
    parameter int unsigned GOAL_HARD = GoalHardDef,
    parameter logic [4:0]  LFSR_SEED = 5'b10011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s_i,
    input  logic       tick_100ms_i,
    input  logic       start_i,
    input  logic [1:0] level_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic [2:0] state_o,
    output logic [4:0] time_left_o,
    output logic [4:0] score_o,
    output logic [4:0] goal_o,
    output logic [3:0] mole_pos_o,
    output logic       mole_vis_o,
    output logic       hit_pulse_o,
    output logic       miss_pulse_o,
    output logic       game_over_o,
    output logic       win_o,
    output logic       led_blink_o
);

    state_e     state_q, state_d;
    logic [4:0] time_q, time_d, score_q, score_d, goal_q, goal_d;
    logic [3:0] pos_q, pos_d, life_q, life_d, gap_q, gap_d, reload_q, reload_d;
    logic       hit_q, hit_d, miss_q, miss_d, win_q, win_d, blink_q, blink_d;
    logic [3:0] cand;
    logic       playing;

    mole_lfsr #(
        .Seed (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .cand_o (cand)
    );

    assign playing = (state_q == StSpawn) || (state_q == StShow) || (state_q == StGap);

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        score_d  = score_q;
        goal_d   = goal_q;
        reload_d = reload_q;
        pos_d    = pos_q;
        life_d   = life_q;
        gap_d    = gap_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        win_d    = win_q;
        blink_d  = blink_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone && tick_1s_i) begin
                    blink_d = ~blink_q;
                end
                if (start_i) begin
                    state_d = StSpawn;
                    score_d = '0;
                    time_d  = 5'(GAME_SECS);
                    win_d   = 1'b0;
                    blink_d = 1'b0;
                    unique case (level_i)
                        LvlEasy: begin
                            goal_d   = 5'(GOAL_EASY);
                            reload_d = 4'(LIFE_EASY);
                        end
                        LvlMed: begin
                            goal_d   = 5'(GOAL_MED);
                            reload_d = 4'(LIFE_MED);
                        end
                        default: begin
                            goal_d   = 5'(GOAL_HARD);
                            reload_d = 4'(LIFE_HARD);
                        end
                    endcase
                end
            end
            StSpawn: begin
                // Never repeat the previous cell back to back.
                pos_d   = (cand == pos_q) ? cand + 4'd1 : cand;
                life_d  = reload_q;
                state_d = StShow;
            end
            StShow: begin
                if (key_valid_i) begin
                    if (key_code_i == pos_q) begin
                        score_d = (score_q == 5'd31) ? score_q : score_q + 5'd1;
                        hit_d   = 1'b1;
                        gap_d   = 4'(GAP_TICKS);
                        state_d = StGap;
                    end else begin
                        miss_d = 1'b1;
                    end
                end else if (tick_100ms_i) begin
                    if (life_q == 4'd1) begin
                        miss_d  = 1'b1;
                        gap_d   = 4'(GAP_TICKS);
                        state_d = StGap;
                    end else begin
                        life_d = life_q - 4'd1;
                    end
                end
            end
            StGap: begin
                if (tick_100ms_i) begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q == 4'd1) begin
                        state_d = StSpawn;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Game-time expiry overrides whatever the play state decided this cycle.
        if (playing && tick_1s_i) begin
            if (time_q == 5'd1) begin
                state_d = StDone;
                time_d  = '0;
                score_d = score_q;
                pos_d   = pos_q;
                hit_d   = 1'b0;
                miss_d  = 1'b0;
                win_d   = (score_q >= goal_q);
            end else begin
                time_d = time_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            time_q   <= 5'(GAME_SECS);
            score_q  <= '0;
            goal_q   <= 5'(GOAL_EASY);
            reload_q <= 4'(LIFE_EASY);
            pos_q    <= '0;
            life_q   <= '0;
            gap_q    <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            win_q    <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            score_q  <= score_d;
            goal_q   <= goal_d;
            reload_q <= reload_d;
            pos_q    <= pos_d;
            life_q   <= life_d;
            gap_q    <= gap_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            win_q    <= win_d;
            blink_q  <= blink_d;
        end
    end

    assign state_o      = state_q;
    assign time_left_o  = time_q;
    assign score_o      = score_q;
    assign goal_o       = goal_q;
    assign mole_pos_o   = pos_q;
    assign mole_vis_o   = (state_q == StShow);
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = miss_q;
    assign game_over_o  = (state_q == StDone);
    assign win_o        = win_q;
    assign led_blink_o  = blink_q;

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
Central sequencer for the whack-a-mole game. It runs the game from start to game-over and schedules each mole: when it appears, where it appears, and how long it stays. It also judges keypad hits against the current mole and keeps the score, the remaining game time and the win/lose result. It sits between the clock dividers, the keypad scanner, and the display consumers (dot-matrix renderer, 7-segment display, LED bar).

Parameters:
GAME_SECS, 30, game length in seconds (5-bit; legal range 1..31)
GAP_TICKS, 3, empty-board interval after each mole, in 100 ms ticks
LIFE_EASY, 15, mole lifetime for level 0, in 100 ms ticks
LIFE_MED, 10, mole lifetime for level 1, in 100 ms ticks
LIFE_HARD, 6, mole lifetime for levels 2/3, in 100 ms ticks
GOAL_EASY, 10, target score for level 0
GOAL_MED, 15, target score for level 1
GOAL_HARD, 20, target score for levels 2/3
LFSR_SEED, 5'b10011, reset value of the position LFSR (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick_1s  in  1  one-cycle strobe, 1 Hz
tick_100ms  in  1  one-cycle strobe, 10 Hz
start  in  1  one-cycle strobe from debounced start button
level  in  2  difficulty from switches; 0 easy, 1 medium, 2/3 hard
key_valid  in  1  one-cycle strobe: a key press has been decoded
key_code  in  4  pad index 0..15 of the pressed key, valid with key_valid
state  out  3  current FSM state code
time_left  out  5  seconds remaining
score  out  5  hits this game
goal  out  5  target score latched at game start
mole_pos  out  4  current mole cell, 0..15
mole_vis  out  1  mole is on the board
hit_pulse  out  1  one-cycle strobe: correct hit
miss_pulse  out  1  one-cycle strobe: wrong key or mole timed out
game_over  out  1  game has ended
win  out  1  score>=goal; valid only while game_over=1
led_blink  out  1  end-of-game LED pattern

Behaviour:
- Reset (async): state=IDLE, time_left=GAME_SECS, score=0, goal=GOAL_EASY, mole_pos=0, lfsr=LFSR_SEED. All pulse outputs, mole_vis, game_over, win and led_blink are 0.
- LFSR: 5-bit Fibonacci, polynomial x^5+x^3+1, advances every clk cycle including IDLE, never reaches 0. Candidate position = lfsr[3:0].
- States: IDLE, SPAWN, SHOW, GAP, DONE.
- IDLE: start -> latch goal and life_reload from level; score=0, time_left=GAME_SECS; go to SPAWN. level is ignored outside IDLE and DONE.
- SPAWN (one cycle):
  - mole_pos = candidate, or candidate+1 mod 16 when candidate equals the previous mole_pos.
  - life_cnt = life_reload; go to SHOW.
- SHOW: mole_vis=1; each tick_100ms decrements life_cnt.
  - key_valid with key_code==mole_pos: score+1 (saturates at 31), hit_pulse for 1 cycle, go to GAP.
  - key_valid with a different key_code: miss_pulse, stay in SHOW, score unchanged.
  - tick_100ms while life_cnt==1: miss_pulse, go to GAP.
  - key_valid and life expiry in the same cycle: the key wins.
- GAP: mole_vis=0; gap_cnt loads GAP_TICKS on entry and decrements on each tick_100ms; reaching 0 -> SPAWN. Keys pressed during GAP are ignored (no pulse).
- Game timer: active in SPAWN, SHOW and GAP; tick_1s decrements time_left.
  - On 1->0: go to DONE from any play state, mole_vis=0.
  - Expiry has priority over a same-cycle hit; that hit is not scored and no pulse is issued.
- DONE:
  - game_over=1; win=(score>=goal), registered on entry.
  - led_blink toggles on every tick_1s.
  - time_left holds at 0; score holds.
  - start behaves exactly as in IDLE; it clears game_over, win and led_blink.
- start while in SPAWN/SHOW/GAP is ignored.
- Latency: key_valid to hit_pulse/score update is 1 clk. tick to state change is 1 clk.
- Reset mid-game returns to IDLE immediately; no pulse outputs are produced.

Decomposition:
- Package mole_pkg holds:
  - state enum (IDLE=0, SPAWN=1, SHOW=2, GAP=3, DONE=4);
  - level codes;
  - default LIFE_*/GOAL_* constants;
  - the 5-bit LFSR tap mask.
- One sub-module: mole_lfsr, the 5-bit free-running LFSR with a seed parameter. The FSM, counters and scoring stay in mole_game_ctrl.

Test Plan:
- Reset with GAME_SECS=5 -> state=IDLE, time_left=5, score=0, all strobes 0. level=2, start pulse -> goal=20; SPAWN for 1 cycle, then SHOW with mole_vis=1.
- In SHOW, key_valid with key_code==mole_pos -> next cycle hit_pulse=1, score=1, state=GAP, mole_vis=0. After 3 tick_100ms -> SPAWN, and the new mole_pos differs from the old one.
- In SHOW with level=0, wrong key -> miss_pulse=1, score=0, stays in SHOW. Then 15 tick_100ms with no key -> miss_pulse, state=GAP.
- Five tick_1s during play -> time_left 5,4,3,2,1,0 and state=DONE. Correct key_valid issued in the same cycle as the last tick -> no hit_pulse, score unchanged.
- level=0 with score=10 at expiry -> win=1, game_over=1, led_blink toggles on each tick_1s. Repeat with score=9 -> win=0.
- Assert rst mid-SHOW -> immediate IDLE, mole_vis=0. Then start in DONE -> score=0, time_left=GAME_SECS, game_over=0, state=SPAWN.
